optimsoc_ascii_to_index: RTL and testbench
==========================================

# optimsoc_ascii_to_index

Streaming ASCII-decimal-to-integer parser; the inverse of the package's integer-to-string helper. Accepts one character per cycle on a valid/ready byte stream, such as a UART or debug command channel, and accumulates decimal digits. It emits each completed number as a binary value with an error flag. Used wherever software or a host types tile, node or index numbers into hardware.

## Interface
- `WIDTH`, 10: output value width; default covers 0-999.
- `MAX_DIGITS`, 3: maximum digits per number, excluding any hex prefix.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_data` in 8: ASCII character.
- `in_valid` in 1: character valid.
- `in_ready` out 1: character accepted when `in_valid && in_ready`.
- `out_data` out WIDTH: parsed value.
- `out_error` out 1: number malformed or overflowed.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.

## Operation
- Character classes:
  - Digit: 0x30-0x39.
  - Separator: 0x00, 0x09, 0x0A, 0x0D, 0x20, 0x2C.
  - Anything else is invalid.
- States: IDLE, DEC, HEX (macro only), EMIT.
- IDLE: `in_ready`=1.
  - Separator: dropped; stay in IDLE.
  - Digit d: acc=d, cnt=1, go to DEC.
  - Invalid character: consumed; result = 0 with error; go to EMIT.
- DEC: `in_ready`=1.
  - Digit d: acc=acc*10+d, cnt=cnt+1.
    - If cnt would exceed MAX_DIGITS, or acc would exceed 2^WIDTH-1, set sticky `ovf`.
    - Once `ovf` is set, acc is frozen and further digits are consumed.
  - Separator: consumed; go to EMIT.
  - Invalid character: consumed; set `bad`; go to EMIT.
- EMIT: `in_ready`=0, `out_valid`=1.
  - `out_data`:
    - all-ones if `ovf`;
    - otherwise acc, which on `bad` is the value parsed before the bad character.
  - `out_error` = `ovf | bad`.
  - Hold all outputs stable until `out_ready`. Then clear acc, cnt, `ovf` and `bad`, and go to IDLE.
- Arithmetic: acc is WIDTH+4 bits internally. The multiply is implemented as (acc<<3)+(acc<<1)+d. The overflow compare uses the widened value before truncation.
- Leading zeros count as digits: "0007" with MAX_DIGITS=3 sets `ovf`.

## Timing
- Throughput: one character per cycle in IDLE, DEC and HEX.
- Latency: `out_valid` rises the cycle after the terminating character's handshake. It stays high for at least 1 cycle, and until the cycle in which `out_ready` is sampled high.
- Each completed number costs at least 1 input bubble, the EMIT cycle.
- `in_ready` is combinational from state only; no dependency on `in_valid`.
- Reset values, applied while `rst`=1 and in the first cycle after:
  - state = IDLE;
  - `out_valid`=0, `out_data`=0, `out_error`=0;
  - `in_ready`=0 while `rst` is high.
- Reset mid-number or during EMIT discards the partial or pending result; nothing is emitted.
- `out_ready` high while `out_valid` is low has no effect.
- `in_valid` is ignored in EMIT.

## Configuration
- `OPTIMSOC_ASCII_TO_INDEX_HEX_EN` defined: hex prefix support.
  - In DEC with cnt=1 and acc=0, the character 'x' or 'X' enters HEX with acc=0, cnt=0.
  - HEX accepts 0-9, a-f and A-F: acc=(acc<<4)|d. Overflow rules are the same as in DEC.
  - A separator with cnt=0 (a bare "0x") sets `bad`, then goes to EMIT.
- Macro undefined: no HEX state; 'x' and 'X' are invalid characters.

## Test plan
- "42\n", `out_ready`=1 -> one result: `out_data`=42, `out_error`=0. `out_valid` rises the cycle after the '\n' handshake.
- "  7,999 " -> two results: 7 then 999, both error-free. Leading spaces are dropped with no output.
- "1000 " with WIDTH=10, MAX_DIGITS=3 -> `out_data`=0x3FF, `out_error`=1; all 4 digits consumed.
- "12a " -> `out_data`=12, `out_error`=1. The following ' ' is dropped in IDLE with no second result.
- `out_ready` held low for 5 cycles in EMIT -> `in_ready`=0 and outputs stable throughout. `rst` pulsed on the 3rd cycle -> `out_valid`=0 next cycle, and nothing is emitted.
- With HEX_EN, "0x3e7 0x " -> 999 with no error, then 0 with `out_error`=1. Without HEX_EN, "0x3 " -> `out_data`=0, `out_error`=1.

Source files
------------

// File: rtl/optimsoc_ascii_to_index.sv
// Streaming ASCII-decimal-to-integer parser.
// Takes one character per cycle on a valid/ready byte stream, accumulates decimal
// digits and emits each completed number with an error flag (malformed or overflowed).
// Optional hex prefix ("0x"/"0X") support is enabled by defining
// OPTIMSOC_ASCII_TO_INDEX_HEX_EN; the default build parses decimal only.
module optimsoc_ascii_to_index #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_error,
  output logic             out_valid,
  input  logic             out_ready
);

  // Accumulator carries 4 guard bits so a single step never wraps before the compare.
  localparam int unsigned AccW = WIDTH + 4;
  localparam int unsigned CntW = $clog2(MAX_DIGITS + 2);

  localparam logic [AccW-1:0] AccMax = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_DIGITS);

`ifdef OPTIMSOC_ASCII_TO_INDEX_HEX_EN
  typedef enum logic [1:0] {StIdle, StDec, StHex, StEmit} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDec, StEmit} state_e;
`endif

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            bad_q, bad_d;

  logic            accept;
  logic            is_digit;
  logic            is_sep;
  logic [CntW-1:0] cnt_inc;
  logic [AccW-1:0] dec_wide;
  logic            dec_ovf;

  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_sep   = (in_data == 8'h00) || (in_data == 8'h09) || (in_data == 8'h0A) ||
                    (in_data == 8'h0D) || (in_data == 8'h20) || (in_data == 8'h2C);

  // acc*10 + d as shift-add; overflow judged on the widened result.
  assign cnt_inc  = cnt_q + CntW'(1);
  assign dec_wide = (acc_q << 3) + (acc_q << 1) + {{(AccW-4){1'b0}}, in_data[3:0]};
  assign dec_ovf  = (cnt_inc > CntMax) || (dec_wide > AccMax);

`ifdef OPTIMSOC_ASCII_TO_INDEX_HEX_EN
  logic            is_hex_alpha;
  logic            is_x;
  logic [3:0]      hex_val;
  logic [AccW-1:0] hex_wide;
  logic            hex_ovf;

  assign is_hex_alpha = ((in_data >= 8'h61) && (in_data <= 8'h66)) ||
                        ((in_data >= 8'h41) && (in_data <= 8'h46));
  assign is_x         = (in_data == 8'h78) || (in_data == 8'h58);
  // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15.
  assign hex_val      = is_hex_alpha ? (in_data[3:0] + 4'd9) : in_data[3:0];
  assign hex_wide     = (acc_q << 4) | {{(AccW-4){1'b0}}, hex_val};
  assign hex_ovf      = (cnt_inc > CntMax) || (hex_wide > AccMax);
`endif

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic: classify the accepted character and update acc/cnt/flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bad_d   = bad_q;
    unique case (state_q)
      // acc and cnt are always zero in StIdle, so a first digit shares the DEC update.
      StIdle, StDec: begin
        if (accept) begin
          if (is_digit) begin
            state_d = StDec;
            if (!ovf_q) begin
              if (dec_ovf) begin
                ovf_d = 1'b1;
              end else begin
                acc_d = dec_wide;
                cnt_d = cnt_inc;
              end
            end
          end
`ifdef OPTIMSOC_ASCII_TO_INDEX_HEX_EN
          else if ((state_q == StDec) && is_x && (cnt_q == CntW'(1)) &&
                   (acc_q == '0) && !ovf_q) begin
            state_d = StHex;
            acc_d   = '0;
            cnt_d   = '0;
          end
`endif
          else if (is_sep) begin
            // Separators in StIdle are simply dropped.
            if (state_q == StDec) state_d = StEmit;
          end else begin
            bad_d   = 1'b1;
            state_d = StEmit;
          end
        end
      end
`ifdef OPTIMSOC_ASCII_TO_INDEX_HEX_EN
      StHex: begin
        if (accept) begin
          if (is_digit || is_hex_alpha) begin
            if (!ovf_q) begin
              if (hex_ovf) begin
                ovf_d = 1'b1;
              end else begin
                acc_d = hex_wide;
                cnt_d = cnt_inc;
              end
            end
          end else begin
            // A bare "0x" is malformed even when properly terminated.
            if (!is_sep || (cnt_q == '0)) bad_d = 1'b1;
            state_d = StEmit;
          end
        end
      end
`endif
      StEmit: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs; all forced inactive while reset is asserted.
  assign in_ready  = !rst && (state_q != StEmit);
  assign out_valid = !rst && (state_q == StEmit);
  assign out_error = out_valid && (ovf_q || bad_q);
  assign out_data  = !out_valid ? '0 : (ovf_q ? {WIDTH{1'b1}} : acc_q[WIDTH-1:0]);

endmodule

// File: tb/tb_optimsoc_ascii_to_index.sv
// Self-checking bench for optimsoc_ascii_to_index (WIDTH=10, MAX_DIGITS=3).
// Directed scenarios plus randomized character streams checked against a
// token-level reference parser. Hex scenario selected by OPTIMSOC_ASCII_TO_INDEX_HEX_EN.
module tb_optimsoc_ascii_to_index;

  localparam int unsigned WIDTH      = 10;
  localparam int unsigned MAX_DIGITS = 3;
  localparam longint      VMAX       = (64'd1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_error;
  logic             out_valid;
  logic             out_ready;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } res_t;

  byte unsigned stim[$];
  byte unsigned pend[$];
  res_t         exp_q[$];

  always #5 clk = ~clk;

  optimsoc_ascii_to_index #(
    .WIDTH     (WIDTH),
    .MAX_DIGITS(MAX_DIGITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_error(out_error),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic bit is_sep(input byte unsigned c);
    return (c == 8'h00) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D) ||
           (c == 8'h20) || (c == 8'h2C);
  endfunction

  function automatic bit is_dig(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic void push_exp(input longint v, input bit e);
    res_t r;
    r.data = v[WIDTH-1:0];
    r.err  = e;
    exp_q.push_back(r);
  endfunction

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) pend.push_back(s[i]);
  endfunction

  // Reference parser: split the pending text into numbers and judge each as a whole.
  function automatic void commit();
    int p = 0;
    int n = pend.size();
    while (p < n) begin
      if (is_sep(pend[p])) begin
        p++;
      end else if (!is_dig(pend[p])) begin
        push_exp(0, 1'b1);
        p++;
      end else begin
        longint v   = 0;
        int     nd  = 0;
        bit     bad = 1'b0;
        bit     ovf;
        while (p < n && is_dig(pend[p])) begin
          v = v * 10 + longint'(pend[p] - 8'h30);
          nd++;
          p++;
        end
        if (p < n) begin
          bad = !is_sep(pend[p]);
          p++;
        end
        ovf = (nd > MAX_DIGITS) || (v > VMAX);
        push_exp(ovf ? VMAX : v, ovf | bad);
      end
    end
    foreach (pend[i]) stim.push_back(pend[i]);
    pend.delete();
  endfunction

  // Streams stim into the DUT and checks every emitted result against exp_q.
  // Entered and left just after a rising edge.
  task automatic run(input int valid_pct, input int ready_pct, input int budget);
    int               cyc  = 0;
    int               tail = 0;
    bit               holding = 1'b0;
    logic [WIDTH-1:0] hold_d = '0;
    logic             hold_e = 1'b0;
    res_t             e;
    while ((stim.size() > 0 || exp_q.size() > 0 || tail < 4) && cyc < budget) begin
      if (stim.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        in_data  = stim[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== !out_valid) begin
        n_err++;
        $display("FAIL in_ready_vs_valid: in_ready=%b out_valid=%b", in_ready, out_valid);
      end
      if (holding) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_error !== hold_e) begin
          n_err++;
          $display("FAIL hold_stable: got v=%b d=%0d e=%b want v=1 d=%0d e=%b",
                   out_valid, out_data, out_error, hold_d, hold_e);
        end
      end
      if (in_valid && in_ready) void'(stim.pop_front());
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got d=%0d e=%b want none", out_data, out_error);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_error !== e.err) begin
            n_err++;
            $display("FAIL result: got d=%0d e=%b want d=%0d e=%b",
                     out_data, out_error, e.data, e.err);
          end
        end
      end
      holding = out_valid && !out_ready;
      hold_d  = out_data;
      hold_e  = out_error;
      if (stim.size() == 0 && exp_q.size() == 0 && !out_valid) tail++;
      else tail = 0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d results pending, want 0", exp_q.size());
      stim.delete();
      exp_q.delete();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h35;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_active: got rdy=%b v=%b d=%0d e=%b want 0 0 0 0",
               in_ready, out_valid, out_data, out_error);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b v=%b d=%0d e=%b want 1 0 0 0",
               in_ready, out_valid, out_data, out_error);
    end
    @(posedge clk);
    #1;
  endtask

  // "42\n" with exact latency: result visible right after the '\n' handshake edge.
  task automatic test_basic();
    byte unsigned s[3] = '{8'h34, 8'h32, 8'h0A};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL basic_pre[%0d]: got v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 10'd42 || out_error !== 1'b0) begin
      n_err++;
      $display("FAIL basic_42: got v=%b d=%0d e=%b want v=1 d=42 e=0",
               out_valid, out_data, out_error);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_consumed: got v=%b want v=0", out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_separators();
    push_str("  7,999 ");
    stim = pend;
    pend.delete();
    push_exp(7, 1'b0);
    push_exp(999, 1'b0);
    run(100, 100, 200);
    stim = '{8'h09, 8'h00, 8'h0D, 8'h35, 8'h0D, 8'h0A, 8'h2C};
    push_exp(5, 1'b0);
    run(70, 60, 200);
  endtask

  task automatic test_overflow();
    push_str("1000 0007 999 0 12345,");
    stim = pend;
    pend.delete();
    push_exp(VMAX, 1'b1);
    push_exp(VMAX, 1'b1);
    push_exp(999, 1'b0);
    push_exp(0, 1'b0);
    push_exp(VMAX, 1'b1);
    run(100, 50, 300);
  endtask

  task automatic test_invalid();
    push_str("12a q 3#");
    stim = pend;
    pend.delete();
    push_exp(12, 1'b1);
    push_exp(0, 1'b1);
    push_exp(3, 1'b1);
    run(80, 80, 200);
  endtask

  task automatic test_hex();
`ifdef OPTIMSOC_ASCII_TO_INDEX_HEX_EN
    push_str("0x3e7 0x 0XaF,0x1000 ");
    stim = pend;
    pend.delete();
    push_exp(999, 1'b0);
    push_exp(0, 1'b1);
    push_exp(175, 1'b0);
    push_exp(VMAX, 1'b1);
`else
    push_str("0x3 X ");
    stim = pend;
    pend.delete();
    push_exp(0, 1'b1);
    push_exp(3, 1'b0);
    push_exp(0, 1'b1);
`endif
    run(100, 100, 200);
  endtask

  // Result held 5 cycles with out_ready low, reset on the 3rd discards it.
  task automatic test_hold_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h35;
    @(posedge clk);
    #1;
    in_data = 8'h20;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h36;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b1;
      if (i == 3) out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (i < 2) begin
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 10'd5 ||
            out_error !== 1'b0) begin
          n_err++;
          $display("FAIL hold[%0d]: got v=%b rdy=%b d=%0d e=%b want v=1 rdy=0 d=5 e=0",
                   i, out_valid, in_ready, out_data, out_error);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_reset[%0d]: got v=%b want v=0", i, out_valid);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    // Reset mid-number drops the partial value.
    stim = '{8'h31, 8'h32};
    run(100, 100, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    stim = '{8'h20, 8'h33, 8'h20};
    push_exp(3, 1'b0);
    run(100, 100, 50);
  endtask

  task automatic gen_random(input int ntok);
    byte unsigned seps[6] = '{8'h00, 8'h09, 8'h0A, 8'h0D, 8'h20, 8'h2C};
    byte unsigned bads[8] = '{8'h61, 8'h71, 8'h5A, 8'h23, 8'h2D, 8'h2E, 8'h3A, 8'h2F};
    for (int i = 0; i < ntok; i++) begin
      int k;
      int nd;
      k = $urandom_range(99);
      if (k < 8) begin
        pend.push_back(bads[$urandom_range(7)]);
      end else if (k < 20) begin
        pend.push_back(seps[$urandom_range(5)]);
      end else begin
        nd = ($urandom_range(9) == 0) ? $urandom_range(6, 4) : $urandom_range(3, 1);
        for (int j = 0; j < nd; j++) pend.push_back(8'h30 + 8'($urandom_range(9)));
        if ($urandom_range(99) < 85) pend.push_back(seps[$urandom_range(5)]);
        else pend.push_back(bads[$urandom_range(7)]);
      end
    end
    pend.push_back(8'h20);
    commit();
  endtask

  task automatic test_random();
    gen_random(150);
    run(60, 50, 20000);
  endtask

  task automatic test_back_to_back();
    gen_random(100);
    run(100, 100, 10000);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_separators();
    test_overflow();
    test_invalid();
    test_hex();
    test_hold_reset();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
